// File: rtl/past_sequence_adder_checker_pkg.sv
// Shared types and helpers for the past_sequence_adder checker: FSM states,
// window length derivation and the saturating increment used by its counters.
package past_sequence_adder_checker_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    CHECK  = 2'd1,
    HALT   = 2'd2
  } state_t;

  // Window length is twice the adder's half-length.
  function automatic int win_len(input int n);
    return 2 * n;
  endfunction

  // Counters hold at max instead of wrapping; callers size the result back down.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/past_sequence_adder_checker_window_sum_golden.sv
// Golden windowed sum: circular buffer plus running sum, delayed so that
// exp_sum lines up with the adder's LAT-cycle pipeline.
module window_sum_golden
  import past_sequence_adder_checker_pkg::*;
#(
  parameter int DW  = 8,
  parameter int N   = 4,
  parameter int LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] inp,
  output logic [DW-1:0] exp_sum
);

  localparam int WIN = win_len(N);
  localparam int PW  = (WIN > 1) ? $clog2(WIN) : 1;

  logic [DW-1:0] win_buf [WIN];
  logic [PW-1:0] wp;
  logic [DW-1:0] sum_q;
  logic [DW-1:0] sum_n;

  // Add the newest sample and drop the one it overwrites (mod 2^DW).
  always_comb begin
    sum_n = sum_q + inp - win_buf[wp];
  end

  // NOTE: the buffer is cleared on reset on purpose, so a mid-run reset drops
  // every old sample; a plain RAM without reset would leak history into the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
      wp    <= '0;
      sum_q <= '0;
    end else begin
      win_buf[wp] <= inp;
      wp          <= (wp == PW'(WIN - 1)) ? '0 : wp + 1'b1;
      sum_q       <= sum_n;
    end
  end

  // sum_q already provides one cycle of delay; the line adds the other LAT-1.
  generate
    if (LAT == 1) begin : g_no_delay
      assign exp_sum = sum_q;
    end else begin : g_delay
      logic [DW-1:0] dly [LAT-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT - 1; i++) dly[i] <= '0;
        end else begin
          dly[0] <= sum_q;
          for (int i = 1; i < LAT - 1; i++) dly[i] <= dly[i-1];
        end
      end

      assign exp_sum = dly[LAT-2];
    end
  endgenerate

endmodule

// File: rtl/past_sequence_adder_checker.sv
// Checks past_sequence_adder output against an aligned golden window sum and
// reports sticky error, check/mismatch counters and first-failure capture.
module past_sequence_adder_checker
  import past_sequence_adder_checker_pkg::*;
#(
  parameter int DW          = 8,
  parameter int N           = 4,
  parameter int LAT         = 4,
  parameter int CW          = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] inp,
  input  logic [DW-1:0] dut_sum,
  output logic [DW-1:0] exp_sum,
  output logic          check_en,
  output logic          err,
  output logic [CW-1:0] mismatch_cnt,
  output logic [CW-1:0] check_cnt,
  output logic [DW-1:0] first_exp,
  output logic [DW-1:0] first_got,
  output logic          halted
);

  localparam int WIN  = win_len(N);
  localparam int WARM = WIN + LAT;
  localparam int SCW  = $clog2(WARM + 1);

  localparam logic [SCW-1:0] WARM_LAST = SCW'(WARM - 1);
  localparam logic [CW-1:0]  CNT_MAX   = '1;

  state_t         state;
  logic [SCW-1:0] sample_cnt;
  logic [SCW-1:0] sample_cnt_inc;
  logic [CW-1:0]  check_cnt_inc;
  logic [CW-1:0]  mismatch_cnt_inc;
  logic           mismatch;

  window_sum_golden #(
    .DW  (DW),
    .N   (N),
    .LAT (LAT)
  ) u_golden (
    .clk     (clk),
    .rst     (rst),
    .inp     (inp),
    .exp_sum (exp_sum)
  );

  always_comb begin
    sample_cnt_inc   = SCW'(sat_inc(32'(sample_cnt), 32'(WARM)));
    check_cnt_inc    = CW'(sat_inc(32'(check_cnt), 32'(CNT_MAX)));
    mismatch_cnt_inc = CW'(sat_inc(32'(mismatch_cnt), 32'(CNT_MAX)));
    mismatch         = (dut_sum != exp_sum);
  end

  // NOTE: every register here uses <= so all updates see the same pre-edge
  // values; blocking assignments would make err and first_* order-dependent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WARMUP;
      sample_cnt   <= '0;
      check_en     <= 1'b0;
      err          <= 1'b0;
      mismatch_cnt <= '0;
      check_cnt    <= '0;
      first_exp    <= '0;
      first_got    <= '0;
      halted       <= 1'b0;
    end else begin
      sample_cnt <= sample_cnt_inc;
      case (state)
        WARMUP: begin
          // Evaluated on the incremented count so checking starts once the
          // first full window has propagated to exp_sum.
          if (sample_cnt_inc >= WARM_LAST) begin
            state    <= CHECK;
            check_en <= 1'b1;
          end
        end
        CHECK: begin
          check_cnt <= check_cnt_inc;
          if (mismatch) begin
            mismatch_cnt <= mismatch_cnt_inc;
            err          <= 1'b1;
            if (!err) begin
              first_exp <= exp_sum;
              first_got <= dut_sum;
            end
            if (STOP_ON_ERR) begin
              state    <= HALT;
              check_en <= 1'b0;
              halted   <= 1'b1;
            end
          end
        end
        HALT: begin
          // Status is frozen until reset; the golden window keeps running.
        end
        default: begin
          state    <= WARMUP;
          check_en <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_past_sequence_adder_checker.sv
// Directed bench for past_sequence_adder_checker: three instances (default,
// stop-on-error, 4-bit counters) driven with counter stimulus 0,1,2,...
module tb_past_sequence_adder_checker;

  localparam int DW  = 8;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] inp = '0;
  logic [DW-1:0] dsum_a = '0, dsum_b = '0, dsum_c = '0;

  logic [DW-1:0] exp_a, fexp_a, fgot_a;
  logic          en_a, err_a, halt_a;
  logic [15:0]   mcnt_a, ccnt_a;

  logic [DW-1:0] exp_b, fexp_b, fgot_b;
  logic          en_b, err_b, halt_b;
  logic [15:0]   mcnt_b, ccnt_b;

  logic [DW-1:0] exp_c, fexp_c, fgot_c;
  logic          en_c, err_c, halt_c;
  logic [3:0]    mcnt_c, ccnt_c;

  int tests_run    = 0;
  int tests_failed = 0;
  int fa1 = -1, fa2 = -1, fb = -1;

  always #5 clk = ~clk;

  past_sequence_adder_checker #(.DW(8), .N(4), .LAT(4), .CW(16), .STOP_ON_ERR(1'b0)) u_a (
    .clk(clk), .rst(rst), .inp(inp), .dut_sum(dsum_a), .exp_sum(exp_a), .check_en(en_a),
    .err(err_a), .mismatch_cnt(mcnt_a), .check_cnt(ccnt_a), .first_exp(fexp_a),
    .first_got(fgot_a), .halted(halt_a));

  past_sequence_adder_checker #(.DW(8), .N(4), .LAT(4), .CW(16), .STOP_ON_ERR(1'b1)) u_b (
    .clk(clk), .rst(rst), .inp(inp), .dut_sum(dsum_b), .exp_sum(exp_b), .check_en(en_b),
    .err(err_b), .mismatch_cnt(mcnt_b), .check_cnt(ccnt_b), .first_exp(fexp_b),
    .first_got(fgot_b), .halted(halt_b));

  past_sequence_adder_checker #(.DW(8), .N(4), .LAT(4), .CW(4), .STOP_ON_ERR(1'b0)) u_c (
    .clk(clk), .rst(rst), .inp(inp), .dut_sum(dsum_c), .exp_sum(exp_c), .check_en(en_c),
    .err(err_c), .mismatch_cnt(mcnt_c), .check_cnt(ccnt_c), .first_exp(fexp_c),
    .first_got(fgot_c), .halted(halt_c));

  // Sum of the 8 counter samples ending at index e (negative indices are pre-reset zeros).
  function automatic logic [DW-1:0] window_sum(input int e);
    logic [DW-1:0] s;
    s = '0;
    for (int j = e - 7; j <= e; j++) if (j >= 0) s += 8'(j);
    return s;
  endfunction

  // Drive cycle k's inputs, advance one clock, land #1 after the edge.
  task automatic drive_cycle(input int k);
    inp    = 8'(k);
    dsum_a = (k == fa1) ? 8'hFF : (k == fa2) ? 8'h11 : window_sum(k - LAT);
    dsum_b = (k == fb) ? 8'hFF : window_sum(k - LAT);
    dsum_c = window_sum(k - LAT);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; inp = '0; dsum_a = '0; dsum_b = '0; dsum_c = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fa1 = -1; fa2 = -1; fb = -1;
    do_reset();
    tests_run++;
    if ({exp_a, en_a, err_a, mcnt_a, ccnt_a, fexp_a, fgot_a, halt_a} !== '0) begin
      tests_failed++; $display("FAIL reset_a: got exp=%0d en=%0b err=%0b m=%0d c=%0d expected all 0",
                               exp_a, en_a, err_a, mcnt_a, ccnt_a);
    end
    tests_run++;
    if ({halt_b, err_b, ccnt_b} !== '0) begin
      tests_failed++; $display("FAIL reset_b: got halt=%0b err=%0b c=%0d expected 0", halt_b, err_b, ccnt_b);
    end
  endtask

  task automatic test_warmup();
    logic [DW-1:0] exp_tab [4];
    exp_tab[0] = 8'd28; exp_tab[1] = 8'd36; exp_tab[2] = 8'd44; exp_tab[3] = 8'd52;
    do_reset();
    for (int k = 0; k <= 14; k++) begin
      if (k <= 11) begin
        tests_run++;
        if (en_a !== (k >= 11)) begin
          tests_failed++; $display("FAIL warmup_en[%0d]: got %0b expected %0b", k, en_a, (k >= 11));
        end
      end
      if (k >= 11) begin
        tests_run++;
        if (exp_a !== exp_tab[k-11]) begin
          tests_failed++; $display("FAIL warmup_exp[%0d]: got %0d expected %0d", k, exp_a, exp_tab[k-11]);
        end
      end
      drive_cycle(k);
    end
    tests_run++;
    if (err_a !== 1'b0) begin
      tests_failed++; $display("FAIL warmup_err: got %0b expected 0", err_a);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      if (k == 44) begin
        tests_run++;
        if (exp_a !== 8'd36) begin
          tests_failed++; $display("FAIL wrap_exp44: got %0d expected 36", exp_a);
        end
      end else if (k >= 11) begin
        tests_run++;
        if (exp_a !== window_sum(k - LAT)) begin
          tests_failed++; $display("FAIL wrap_exp[%0d]: got %0d expected %0d", k, exp_a, window_sum(k - LAT));
        end
      end
      drive_cycle(k);
    end
    tests_run++;
    if (mcnt_a !== 16'd0 || err_a !== 1'b0) begin
      tests_failed++; $display("FAIL wrap_clean: got m=%0d err=%0b expected 0/0", mcnt_a, err_a);
    end
    tests_run++;
    if (ccnt_a !== 16'd289) begin
      tests_failed++; $display("FAIL wrap_checks: got %0d expected 289", ccnt_a);
    end
  endtask

  task automatic test_fault();
    fa1 = 20; fa2 = 30; fb = 20;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      if (k == 20) begin
        tests_run++;
        if (exp_a !== 8'd100 || halt_b !== 1'b0 || err_a !== 1'b0) begin
          tests_failed++; $display("FAIL fault_pre: got exp=%0d halt_b=%0b err=%0b expected 100/0/0",
                                   exp_a, halt_b, err_a);
        end
      end
      if (k == 21) begin
        tests_run++;
        if ({err_a, mcnt_a, fexp_a, fgot_a} !== {1'b1, 16'd1, 8'd100, 8'hFF}) begin
          tests_failed++; $display("FAIL fault_first: got err=%0b m=%0d fe=%0d fg=%0h expected 1/1/100/ff",
                                   err_a, mcnt_a, fexp_a, fgot_a);
        end
        tests_run++;
        if ({halt_b, en_b, err_b, ccnt_b, mcnt_b} !== {1'b1, 1'b0, 1'b1, 16'd10, 16'd1}) begin
          tests_failed++; $display("FAIL stop_halt: got halt=%0b en=%0b err=%0b c=%0d m=%0d expected 1/0/1/10/1",
                                   halt_b, en_b, err_b, ccnt_b, mcnt_b);
        end
      end
      if (k == 31) begin
        tests_run++;
        if ({mcnt_a, fexp_a, fgot_a, ccnt_a} !== {16'd2, 8'd100, 8'hFF, 16'd20}) begin
          tests_failed++; $display("FAIL fault_second: got m=%0d fe=%0d fg=%0h c=%0d expected 2/100/ff/20",
                                   mcnt_a, fexp_a, fgot_a, ccnt_a);
        end
        tests_run++;
        if ({halt_b, err_b, ccnt_b, mcnt_b} !== {1'b1, 1'b1, 16'd10, 16'd1}) begin
          tests_failed++; $display("FAIL stop_frozen: got halt=%0b err=%0b c=%0d m=%0d expected 1/1/10/1",
                                   halt_b, err_b, ccnt_b, mcnt_b);
        end
      end
      drive_cycle(k);
    end
    fa1 = -1; fa2 = -1; fb = -1;
  endtask

  task automatic test_mid_reset();
    fa1 = 20;
    do_reset();
    for (int k = 0; k < 50; k++) drive_cycle(k);
    tests_run++;
    if (err_a !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_pre: got err=%0b expected 1", err_a);
    end
    fa1 = -1;
    do_reset();
    tests_run++;
    if ({exp_a, en_a, err_a, mcnt_a, ccnt_a, fexp_a, fgot_a, halt_a} !== '0) begin
      tests_failed++; $display("FAIL midrst_zero: got exp=%0d en=%0b err=%0b m=%0d c=%0d fe=%0d expected all 0",
                               exp_a, en_a, err_a, mcnt_a, ccnt_a, fexp_a);
    end
    for (int k = 0; k <= 11; k++) begin
      tests_run++;
      if (en_a !== (k >= 11)) begin
        tests_failed++; $display("FAIL midrst_en[%0d]: got %0b expected %0b", k, en_a, (k >= 11));
      end
      if (k == 11) begin
        tests_run++;
        if (exp_a !== 8'd28) begin
          tests_failed++; $display("FAIL midrst_exp: got %0d expected 28", exp_a);
        end
      end
      drive_cycle(k);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      if (k == 25 || k == 26 || k == 31 || k == 40) begin
        tests_run++;
        if (ccnt_c !== ((k == 25) ? 4'd14 : 4'd15)) begin
          tests_failed++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, ccnt_c, (k == 25) ? 14 : 15);
        end
      end
      if (k == 31) begin
        tests_run++;
        if (ccnt_a !== 16'd20 || mcnt_c !== 4'd0) begin
          tests_failed++; $display("FAIL sat_ref: got c_a=%0d m_c=%0d expected 20/0", ccnt_a, mcnt_c);
        end
      end
      drive_cycle(k);
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_wrap();
    test_fault();
    test_mid_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
